tlm_fifo: RTL and testbench

- Synthesizable, single-clock, first-in-first-out channel between a producer thread and a consumer thread.
- Blocking put/get semantics map onto valid/ready handshakes:
  - a put stalls while the FIFO is full;
  - a get stalls while it is empty.
- Data order is strictly preserved.
- Default depth of 1 gives a one-entry mailbox between the two agents.

---
 rtl/tlm_fifo_pkg.sv | 28 ++
 rtl/tlm_fifo_ctrl.sv | 74 +++++++
 rtl/tlm_fifo.sv | 83 ++++++++
 tb/tb_tlm_fifo.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlm_fifo_pkg.sv
// tlm_fifo_pkg
// Shared constants, types and helpers for the tlm_fifo channel.
// Contents:
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default payload width and entry count
//   data_t                        : signed payload word at the default width
//   occ_op_e                      : occupancy update selected by {put, get}
//   ptrWidth()                    : pointer width for a given depth (min 1)
package tlm_fifo_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 1;

  typedef logic signed [DEFAULT_WIDTH-1:0] data_t;

  // Encoding is chosen so that {put_fire, get_fire} casts straight onto it.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_GET  = 2'b01,
    OP_PUT  = 2'b10,
    OP_BOTH = 2'b11
  } occ_op_e;

  // A one-entry FIFO still needs a 1-bit pointer so the index is never zero-width.
  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tlm_fifo_ctrl.sv
// tlm_fifo_ctrl
// Pointer, occupancy and flag bookkeeping for tlm_fifo.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_flush           : synchronous clear back to the reset state
//   i_putFire         : a word is enqueued this cycle
//   i_getFire         : the head word is dequeued this cycle
//   o_wrPtr, o_rdPtr  : storage indices for the next write / current head
//   o_used            : number of stored entries
//   o_empty, o_full   : used == 0 / used == DEPTH
module tlm_fifo_ctrl
  import tlm_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int PW    = ptrWidth(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_putFire,
  input  logic          i_getFire,
  output logic [PW-1:0] o_wrPtr,
  output logic [PW-1:0] o_rdPtr,
  output logic [CW-1:0] o_used,
  output logic          o_empty,
  output logic          o_full
);

  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_used;
  occ_op_e       w_op;

  assign w_op = occ_op_e'({i_putFire, i_getFire});

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (i_putFire)
        r_wrPtr <= (r_wrPtr == PW'(DEPTH - 1)) ? '0 : r_wrPtr + PW'(1);
      if (i_getFire)
        r_rdPtr <= (r_rdPtr == PW'(DEPTH - 1)) ? '0 : r_rdPtr + PW'(1);
    end
  end

  // A simultaneous put and get leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_used <= '0;
    end else if (i_flush) begin
      r_used <= '0;
    end else begin
      case (w_op)
        OP_PUT:  r_used <= r_used + CW'(1);
        OP_GET:  r_used <= r_used - CW'(1);
        default: r_used <= r_used;
      endcase
    end
  end

  assign o_wrPtr = r_wrPtr;
  assign o_rdPtr = r_rdPtr;
  assign o_used  = r_used;
  assign o_empty = (r_used == '0);
  assign o_full  = (r_used == CW'(DEPTH));

endmodule

// File: rtl/tlm_fifo.sv
// tlm_fifo
// Single-clock FIFO channel mapping blocking put/get onto valid/ready.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : synchronous clear, beats put and get
//   put_valid, put_data  : producer offer
//   put_ready            : not full (independent of get_ready)
//   get_valid, get_data  : show-ahead head word, zero while empty
//   get_ready            : consumer takes the head word
//   used                 : occupancy count
//   is_empty, is_full    : occupancy flags
module tlm_fifo
  import tlm_fifo_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             put_valid,
  input  logic [WIDTH-1:0] put_data,
  output logic             put_ready,
  output logic             get_valid,
  output logic [WIDTH-1:0] get_data,
  input  logic             get_ready,
  output logic [CW-1:0]    used,
  output logic             is_empty,
  output logic             is_full
);

  localparam int PW = ptrWidth(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    w_wrPtr;
  logic [PW-1:0]    w_rdPtr;
  logic             w_putFire;
  logic             w_getFire;

  // The ready/valid terms gate the handshakes first, so an X on put_valid or
  // get_ready while that side cannot fire still resolves to no event.
  assign put_ready = !is_full;
  assign get_valid = !is_empty;
  assign w_putFire = put_ready && put_valid;
  assign w_getFire = get_valid && get_ready;

  tlm_fifo_ctrl #(
    .DEPTH (DEPTH),
    .CW    (CW),
    .PW    (PW)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (flush),
    .i_putFire (w_putFire),
    .i_getFire (w_getFire),
    .o_wrPtr   (w_wrPtr),
    .o_rdPtr   (w_rdPtr),
    .o_used    (used),
    .o_empty   (is_empty),
    .o_full    (is_full)
  );

  // Storage is not reset; a word offered during flush is dropped.
  always_ff @(posedge clk) begin
    if (w_putFire && !flush)
      r_mem[w_wrPtr] <= put_data;
  end

  // Show-ahead read straight from the head entry, forced to zero when empty.
  assign get_data = is_empty ? '0 : r_mem[w_rdPtr];

`ifndef SYNTHESIS
  a_noWriteFull: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_putFire && is_full));
  a_noReadEmpty: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_getFire && is_empty));
  a_usedBound: assert property (@(posedge clk) disable iff (!rst_n)
    used <= CW'(DEPTH));
`endif

endmodule

// File: tb/tb_tlm_fifo.sv
module tb_tlm_fifo;

  logic        clk;
  logic        rst_n;

  logic        flush1;
  logic        putValid1;
  logic [31:0] putData1;
  logic        putReady1;
  logic        getValid1;
  logic [31:0] getData1;
  logic        getReady1;
  logic [0:0]  used1;
  logic        empty1;
  logic        full1;

  logic        flush4;
  logic        putValid4;
  logic [31:0] putData4;
  logic        putReady4;
  logic        getValid4;
  logic [31:0] getData4;
  logic        getReady4;
  logic [2:0]  used4;
  logic        empty4;
  logic        full4;

  int testsRun;
  int testsFailed;

  tlm_fifo #(.WIDTH(32), .DEPTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush1),
    .put_valid (putValid1),
    .put_data  (putData1),
    .put_ready (putReady1),
    .get_valid (getValid1),
    .get_data  (getData1),
    .get_ready (getReady1),
    .used      (used1),
    .is_empty  (empty1),
    .is_full   (full1)
  );

  tlm_fifo #(.WIDTH(32), .DEPTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush4),
    .put_valid (putValid4),
    .put_data  (putData4),
    .put_ready (putReady4),
    .get_valid (getValid4),
    .get_data  (getData4),
    .get_ready (getReady4),
    .used      (used4),
    .is_empty  (empty4),
    .is_full   (full4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    testsRun++;
    if (used1 !== 1'd0 || empty1 !== 1'b1 || full1 !== 1'b0 || putReady1 !== 1'b1 || getValid1 !== 1'b0 || getData1 !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_d1: used=%0d empty=%b full=%b prdy=%b gval=%b data=%0d expected 0 1 0 1 0 0", used1, empty1, full1, putReady1, getValid1, getData1);
    end
    testsRun++;
    if (used4 !== 3'd0 || empty4 !== 1'b1 || full4 !== 1'b0 || putReady4 !== 1'b1 || getValid4 !== 1'b0 || getData4 !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_d4: used=%0d empty=%b full=%b prdy=%b gval=%b data=%0d expected 0 1 0 1 0 0", used4, empty4, full4, putReady4, getValid4, getData4);
    end
    #9;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_depth1_stream();
    getReady1 = 1'b1;
    putValid1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      putData1 = 32'(k);
      step();
      testsRun++;
      if (used1 !== 1'd1 || full1 !== 1'b1 || putReady1 !== 1'b0 || getValid1 !== 1'b1 || getData1 !== 32'(k)) begin
        testsFailed++;
        $display("[TB] FAIL d1_put_%0d: used=%0d full=%b prdy=%b gval=%b data=%0d expected 1 1 0 1 %0d", k, used1, full1, putReady1, getValid1, getData1, k);
      end
      step();
      testsRun++;
      if (used1 !== 1'd0 || empty1 !== 1'b1 || putReady1 !== 1'b1 || getValid1 !== 1'b0 || getData1 !== 32'd0) begin
        testsFailed++;
        $display("[TB] FAIL d1_get_%0d: used=%0d empty=%b prdy=%b gval=%b data=%0d expected 0 1 1 0 0", k, used1, empty1, putReady1, getValid1, getData1);
      end
    end
    putValid1 = 1'b0;
    getReady1 = 1'b0;
  endtask

  task automatic test_fill_hold();
    logic [2:0]  expUsed [5];
    logic [31:0] expData [5];
    expUsed = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    expData = '{32'd11, 32'd12, 32'd13, 32'd14, 32'd0};
    getReady4 = 1'b0;
    putValid4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      putData4 = 32'(10 + k);
      step();
    end
    testsRun++;
    if (used4 !== 3'd4 || full4 !== 1'b1 || putReady4 !== 1'b0 || getData4 !== 32'd10) begin
      testsFailed++;
      $display("[TB] FAIL fill_full: used=%0d full=%b prdy=%b data=%0d expected 4 1 0 10", used4, full4, putReady4, getData4);
    end
    putData4 = 32'd14;
    step();
    step();
    testsRun++;
    if (used4 !== 3'd4 || getData4 !== 32'd10) begin
      testsFailed++;
      $display("[TB] FAIL fill_hold: used=%0d data=%0d expected 4 10", used4, getData4);
    end
    getReady4 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 1) putValid4 = 1'b0;
      testsRun++;
      if (used4 !== expUsed[k] || getData4 !== expData[k]) begin
        testsFailed++;
        $display("[TB] FAIL fill_drain_%0d: used=%0d data=%0d expected %0d %0d", k, used4, getData4, expUsed[k], expData[k]);
      end
    end
    getReady4 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] expSeq [8];
    expSeq = '{32'd20, 32'd21, 32'd30, 32'd31, 32'd32, 32'd33, 32'd34, 32'd35};
    getReady4 = 1'b0;
    putValid4 = 1'b1;
    putData4  = 32'd20;
    step();
    putData4  = 32'd21;
    step();
    testsRun++;
    if (used4 !== 3'd2 || getData4 !== 32'd20) begin
      testsFailed++;
      $display("[TB] FAIL b2b_prefill: used=%0d data=%0d expected 2 20", used4, getData4);
    end
    getReady4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      putData4 = 32'(30 + i);
      step();
      testsRun++;
      if (used4 !== 3'd2 || getData4 !== expSeq[i + 1]) begin
        testsFailed++;
        $display("[TB] FAIL b2b_stream_%0d: used=%0d data=%0d expected 2 %0d", i, used4, getData4, expSeq[i + 1]);
      end
    end
    putValid4 = 1'b0;
    step();
    testsRun++;
    if (used4 !== 3'd1 || getData4 !== expSeq[7]) begin
      testsFailed++;
      $display("[TB] FAIL b2b_tail: used=%0d data=%0d expected 1 %0d", used4, getData4, expSeq[7]);
    end
    step();
    testsRun++;
    if (used4 !== 3'd0 || empty4 !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_empty: used=%0d empty=%b expected 0 1", used4, empty4);
    end
    getReady4 = 1'b0;
  endtask

  task automatic test_empty_get();
    getReady4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) getReady4 = 1'bx;
      else getReady4 = 1'b1;
      step();
      testsRun++;
      if (getValid4 !== 1'b0 || used4 !== 3'd0 || getData4 !== 32'd0) begin
        testsFailed++;
        $display("[TB] FAIL empty_get_%0d: gval=%b used=%0d data=%0d expected 0 0 0", i, getValid4, used4, getData4);
      end
    end
    getReady4 = 1'b1;
    putValid4 = 1'b1;
    putData4  = 32'd7;
    step();
    putValid4 = 1'b0;
    testsRun++;
    if (getValid4 !== 1'b1 || getData4 !== 32'd7 || used4 !== 3'd1) begin
      testsFailed++;
      $display("[TB] FAIL empty_then_put: gval=%b data=%0d used=%0d expected 1 7 1", getValid4, getData4, used4);
    end
    step();
    testsRun++;
    if (getValid4 !== 1'b0 || used4 !== 3'd0) begin
      testsFailed++;
      $display("[TB] FAIL empty_then_get: gval=%b used=%0d expected 0 0", getValid4, used4);
    end
    getReady4 = 1'b0;
  endtask

  task automatic test_flush();
    getReady4 = 1'b0;
    putValid4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      putData4 = 32'(40 + k);
      step();
    end
    testsRun++;
    if (used4 !== 3'd3 || getData4 !== 32'd40) begin
      testsFailed++;
      $display("[TB] FAIL flush_prefill: used=%0d data=%0d expected 3 40", used4, getData4);
    end
    flush4   = 1'b1;
    putData4 = 32'd99;
    #1;
    testsRun++;
    if (putReady4 !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL flush_prdy: prdy=%b expected 1", putReady4);
    end
    step();
    flush4    = 1'b0;
    putValid4 = 1'b0;
    testsRun++;
    if (used4 !== 3'd0 || empty4 !== 1'b1 || getValid4 !== 1'b0 || getData4 !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL flush_clear: used=%0d empty=%b gval=%b data=%0d expected 0 1 0 0", used4, empty4, getValid4, getData4);
    end
    step();
    testsRun++;
    if (getValid4 !== 1'b0 || used4 !== 3'd0) begin
      testsFailed++;
      $display("[TB] FAIL flush_dropped: gval=%b used=%0d expected 0 0", getValid4, used4);
    end
    putValid4 = 1'b1;
    putData4  = 32'd50;
    step();
    putValid4 = 1'b0;
    testsRun++;
    if (getData4 !== 32'd50 || used4 !== 3'd1) begin
      testsFailed++;
      $display("[TB] FAIL flush_after_put: data=%0d used=%0d expected 50 1", getData4, used4);
    end
  endtask

  task automatic test_async_reset();
    getReady4 = 1'b0;
    putValid4 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      putData4 = 32'(60 + k);
      step();
    end
    putValid4 = 1'b0;
    testsRun++;
    if (used4 !== 3'd3) begin
      testsFailed++;
      $display("[TB] FAIL areset_prefill: used=%0d expected 3", used4);
    end
    #2;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (used4 !== 3'd0 || empty4 !== 1'b1 || full4 !== 1'b0 || putReady4 !== 1'b1 || getValid4 !== 1'b0 || getData4 !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL areset_now: used=%0d empty=%b full=%b prdy=%b gval=%b data=%0d expected 0 1 0 1 0 0", used4, empty4, full4, putReady4, getValid4, getData4);
    end
    #2;
    rst_n = 1'b1;
    putValid4 = 1'b1;
    putData4  = 32'd70;
    step();
    putData4  = 32'd71;
    step();
    putValid4 = 1'b0;
    testsRun++;
    if (used4 !== 3'd2 || getData4 !== 32'd70) begin
      testsFailed++;
      $display("[TB] FAIL areset_first: used=%0d data=%0d expected 2 70", used4, getData4);
    end
    getReady4 = 1'b1;
    step();
    getReady4 = 1'b0;
    testsRun++;
    if (used4 !== 3'd1 || getData4 !== 32'd71) begin
      testsFailed++;
      $display("[TB] FAIL areset_second: used=%0d data=%0d expected 1 71", used4, getData4);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n     = 1'b0;
    flush1    = 1'b0;
    putValid1 = 1'b0;
    putData1  = 32'd0;
    getReady1 = 1'b0;
    flush4    = 1'b0;
    putValid4 = 1'b0;
    putData4  = 32'd0;
    getReady4 = 1'b0;

    test_reset();
    test_depth1_stream();
    test_fill_hold();
    test_back_to_back();
    test_empty_get();
    test_flush();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
